// File: rtl/nibble_serial_adder.sv
// Serial wide adder: one 4-bit RCA slice reused across NIBBLES cycles,
// with the inter-nibble carry held in a register between cycles.
//
// Ports:
//   clk, rst_n      clock; synchronous active-low reset
//   start           request an add (sampled in IDLE or DONE only)
//   a, b, cin       operands, captured on the accepting edge
//   busy            high while the nibble adds are in progress
//   done            one-cycle pulse when sum/cout/overflow are published
//   sum, cout       published result {cout,sum} = a + b + cin
//   overflow        two's-complement overflow of the W-bit add

module RCA (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       carry
);
    logic [4:0] c;

    always_comb begin
        c    = '0;
        sum  = '0;
        c[0] = cin;
        for (int i = 0; i < 4; i++) begin
            sum[i]  = a[i] ^ b[i] ^ c[i];
            c[i+1]  = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
        carry = c[4];
    end
endmodule

module nibble_serial_adder #(
    parameter int NIBBLES = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [4*NIBBLES-1:0] a,
    input  logic [4*NIBBLES-1:0] b,
    input  logic                 cin,
    output logic                 busy,
    output logic                 done,
    output logic [4*NIBBLES-1:0] sum,
    output logic                 cout,
    output logic                 overflow
);
    localparam int W  = 4 * NIBBLES;
    localparam int IW = $clog2(NIBBLES);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t         state, state_nx;
    logic [W-1:0]   a_q, b_q, acc, acc_upd;
    logic           carry_q;
    logic [IW-1:0]  idx;
    logic [IW+1:0]  base;
    logic [3:0]     rca_sum;
    logic           rca_carry;
    logic           last;
    logic           accept;

    // Bit offset of the current nibble.
    assign base = {idx, 2'b00};
    assign last = (idx == IW'(NIBBLES - 1));

    RCA u_rca (
        .a     (a_q[base +: 4]),
        .b     (b_q[base +: 4]),
        .cin   (carry_q),
        .sum   (rca_sum),
        .carry (rca_carry)
    );

    // Shadow result with the current nibble merged, so the publishing
    // edge can copy a complete word in one step.
    always_comb begin
        acc_upd = acc;
        acc_upd[base +: 4] = rca_sum;
    end

    always_comb begin
        state_nx = state;
        accept   = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    accept   = 1'b1;
                    state_nx = ADD;
                end
            end
            ADD: begin
                if (last) state_nx = DONE;
            end
            DONE: begin
                if (start) begin
                    accept   = 1'b1;
                    state_nx = ADD;
                end else begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_q      <= '0;
            b_q      <= '0;
            carry_q  <= 1'b0;
            idx      <= '0;
            acc      <= '0;
            sum      <= '0;
            cout     <= 1'b0;
            overflow <= 1'b0;
        end else if (accept) begin
            a_q     <= a;
            b_q     <= b;
            carry_q <= cin;
            idx     <= '0;
        end else if (state == ADD) begin
            acc     <= acc_upd;
            carry_q <= rca_carry;
            if (last) begin
                sum      <= acc_upd;
                cout     <= rca_carry;
                overflow <= (a_q[W-1] == b_q[W-1]) &&
                            (rca_sum[3] != a_q[W-1]);
            end else begin
                idx <= idx + 1'b1;
            end
        end
    end

    assign busy = (state == ADD);
    assign done = (state == DONE);
endmodule

// File: doc/nibble_serial_adder.md
# nibble_serial_adder

Sequential multi-word adder that sums two `4*NIBBLES`-bit operands one nibble per clock through a single instance of the existing 4-bit `RCA` slice. The inter-nibble carry is held in a register between cycles. It sits directly upstream of the `RCA`: it registers the operands, steers one nibble pair plus the registered carry into the slice each cycle, and collects the slice's `sum` and `carry`. It gives wide additions at the cost of one 4-bit adder and N cycles of latency, with a start/done handshake to the surrounding datapath.

## Interface
- `NIBBLES`, default 4: number of 4-bit slices. Operand width W = 4*NIBBLES. Legal range is 2..16.
- `clk` input 1: single clock; all state changes on the rising edge.
- `rst_n` input 1: reset, synchronous and active-low.
- `start` input 1: request an addition. Sampled only in IDLE or DONE.
- `a` input W: operand A, captured on the accepting edge.
- `b` input W: operand B, captured on the accepting edge.
- `cin` input 1: carry into nibble 0, captured on the accepting edge.
- `busy` output 1: high while in ADD.
- `done` output 1: one-cycle pulse when the result is published.
- `sum` output W: result. Holds its value until the next completion.
- `cout` output 1: carry out of the top nibble.
- `overflow` output 1: two's-complement overflow of the W-bit add.

## Operation
- Datapath:
  - `a_q`, `b_q` (W bits), `carry_q` (1 bit), `idx` (clog2(NIBBLES) bits), `acc` (W-bit shadow result).
  - One `RCA` instance, driven by `a_q[4*idx+:4]`, `b_q[4*idx+:4]` and `carry_q`.
- State machine, 3 states: IDLE, ADD, DONE.
  - IDLE: if `start`=1, capture `a`/`b`/`cin` into `a_q`/`b_q`/`carry_q`, set `idx`←0, go to ADD. Otherwise stay.
  - ADD, on each edge:
    - `acc[4*idx+:4]` ← RCA `sum`; `carry_q` ← RCA `carry`.
    - If `idx`=NIBBLES-1:
      - publish: `sum`←completed `acc`, `cout`←RCA `carry`, `overflow`←(`a_q[W-1]`==`b_q[W-1]`) && (RCA `sum[3]` != `a_q[W-1]`);
      - go to DONE.
    - Otherwise `idx`←`idx`+1.
  - DONE: `done`=1 for this single cycle. If `start`=1, accept as in IDLE and go to ADD (back-to-back). Otherwise go to IDLE.
- `start` in ADD is ignored. It is not queued, and the in-flight operands are unaffected.
- Operand inputs are don't-care except on the accepting edge.
- `sum`, `cout` and `overflow` change only on the publishing edge. They are never observed half-updated.
- Arithmetic: `{cout,sum}` = `a` + `b` + `cin`, modulo 2^(W+1). `overflow` follows signed rules on the W-bit result and ignores `cin` sign semantics; `cin` is just an extra LSB addend.

## Timing
- Reset (`rst_n`=0 at an edge):
  - state←IDLE, `idx`←0, `carry_q`←0, `acc`←0;
  - `sum`=0, `cout`=0, `overflow`=0, `done`=0, `busy`=0.
  - This applies from any state, including mid-ADD. The partial result is discarded and not published.
- `busy`=1 exactly when state=ADD. `done`=1 exactly when state=DONE. Both are decoded from registered state with no combinational path from `start`.
- Latency: with `start` accepted at edge E, the nibble adds occur at edges E+1..E+NIBBLES. The result and `done`=1 are visible after edge E+NIBBLES, and `done` drops after edge E+NIBBLES+1.
- Throughput: back-to-back starts give one result every NIBBLES+1 cycles.
- Boundaries:
  - A carry out of nibble k propagates into nibble k+1 on the next edge.
  - A carry out of the top nibble appears only on `cout`, never wrapping into nibble 0.
  - `rst_n`=0 and `start`=1 on the same edge: reset wins.

## Test plan
- Basic add, NIBBLES=4: `a`=0x1234, `b`=0x4321, `cin`=0. Expect `sum`=0x5555, `cout`=0, `overflow`=0, `done` pulse 4 edges after acceptance and lasting 1 cycle, `busy` high for exactly 4 cycles.
- Full carry ripple: 0xFFFF+0x0001, `cin`=0 gives `sum`=0x0000, `cout`=1, `overflow`=0. Then 0xFFFF+0x0000 with `cin`=1 gives the same result.
- Signed overflow: 0x7FFF+0x0001 gives `sum`=0x8000, `cout`=0, `overflow`=1. 0x8000+0x8000 gives `sum`=0x0000, `cout`=1, `overflow`=1.
- `start` held high during ADD with changing `a`/`b`: result equals the operands captured at acceptance, with no extra `done`. `start` high in the DONE cycle is accepted, and the next `done` arrives exactly 5 cycles after the previous one.
- Reset mid-op: assert `rst_n`=0 after the 2nd ADD edge. Expect all outputs 0, state IDLE, no `done`. A new add of 0x00FF+0x0001 then gives 0x0100.
- Output stability: `sum` keeps the prior result throughout a following operation's ADD cycles and changes only together with `done`.
